alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, parametrised successor of the team's combinational 16-bit ALU.
- Keeps the 5-bit opcode map and the 6-bit status layout.
- Adds multi-bit shifts/rotates by a variable count, unsigned multiply and unsigned divide. These run iteratively over several cycles behind a valid/ready handshake.
- Sits between the register file and the writeback stage of the microprocessor datapath.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8.
- CW, $clog2(WIDTH), shift-count width, taken from B[CW-1:0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block idle; request is accepted on a rising edge where in_valid && in_ready.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B, or shift count in B[CW-1:0].
- F  input  5  opcode.
- Cin  input  1  carry/borrow in.
- out_valid  output  1  one-cycle pulse; Result, ResultHi and Status are valid in that cycle and hold until the next pulse.
- Result  output  WIDTH  primary result (MUL low word, DIV quotient).
- ResultHi  output  WIDTH  MUL high word, DIV remainder; 0 for all other ops.
- Status  output  6  [5]C [4]Z [3]N [2]V [1]P(even) [0]AC.

Behaviour:
- Reset: the state machine goes to IDLE. Result, ResultHi, Status and out_valid are 0; in_ready is 0 while rst is high.
- rst asserted mid-operation aborts it: no out_valid pulse, outputs cleared.
- States:
  - IDLE: in_ready=1. Operands and opcode are captured on acceptance. Changes to A/B/F/Cin after acceptance are ignored.
  - RUN: iterates one step per cycle, counter-driven.
  - DONE: out_valid=1 for exactly one cycle, then IDLE.
- in_valid is ignored in RUN and DONE.
- Latency (acceptance edge = cycle 0; out_valid high in the cycle given):
  - single-step ops: cycle 1, via DONE.
  - shifts by count n: n=0 gives cycle 1; otherwise n cycles in RUN and out_valid at cycle n+1.
  - MUL/DIV: WIDTH cycles in RUN, out_valid at cycle WIDTH+1.
  - exception: DIV by zero gives cycle 1.
- Single-step opcodes use the same semantics as the existing ALU, widened to WIDTH:
  - 00001 INC, 00011 DEC, 00100 ADD, 00101 ADC, 00110 SUB, 00111 SBB
  - 01000 AND, 01001 OR, 01010 XOR, 01011 NOT
  - 10000 SHL, 10001 SHR, 10010 SAL, 10011 SAR
  - 10100 ROL, 10101 ROR, 10110 RCL, 10111 RCR
- Unlisted opcode: Result=0, C/V/AC=0, Z=1, P=1, latency 1.
- Multi-step shift opcodes, count n=B[CW-1:0], one bit position per RUN cycle:
  - 11000 SHLN logical left, 11001 SHRN logical right, 11010 SARN arithmetic right, 11011 ROLN rotate left, 11100 RORN rotate right.
- Multi-step arithmetic opcodes:
  - 11101 MUL: unsigned shift-add; {ResultHi,Result} = A*B.
  - 11110 DIV: unsigned restoring division; Result = A/B, ResultHi = A%B.
- Flags:
  - Z, N, P are computed on Result only, for all ops.
  - ADD family: C = carry out of the MSB; V = signed overflow; AC = carry from bit 3 into bit 4.
  - SUB family: C = borrow; V = signed overflow; AC = nibble borrow.
  - 1-bit shifts: C = bit shifted out (A[WIDTH-1] for left, A[0] for right).
  - N-bit shifts: C = last bit shifted/rotated out; n=0 gives Result=A and C=0.
  - MUL: C = V = (ResultHi != 0).
  - DIV: C=0, V=0. Divide by zero gives Result = all ones, ResultHi = A, V=1.
  - Logic ops: C=V=AC=0.
- Back-to-back: the next request can be accepted no earlier than the cycle after DONE.

Test Plan (WIDTH=16):
- ADD: A=0x7FFF, B=0x0001, F=00100, accepted cycle 0 -> out_valid cycle 1 only; Result=0x8000, Status=6'b001101.
- MUL: A=0x1234, B=0x0100 -> out_valid cycle 17; Result=0x3400, ResultHi=0x0012, C=1, V=1, Z=0. in_valid pulses during cycles 1-16 are ignored, in_ready=0 throughout.
- DIV: A=0x0064, B=0x0007 -> cycle 17; Result=0x000E, ResultHi=0x0002. DIV A=0x1234, B=0 -> cycle 1; Result=0xFFFF, ResultHi=0x1234, V=1.
- Shifts with A=0x8001:
  - SHRN, B=4 -> cycle 5; Result=0x0800, C=0.
  - SARN, B=4 -> 0xF800, N=1.
  - RORN, B=1 -> 0xC000, C=1.
  - SHLN, B=0 -> cycle 1; Result=0x8001, C=0.
- Reset/opcode: rst high at cycle 5 of a MUL -> no out_valid, all outputs 0, in_ready=1 in the first cycle after rst drops. F=01100 -> Result=0, Status=6'b010010.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle ops plus iterative multi-bit
// shifts, unsigned multiply and unsigned divide behind a valid/ready handshake.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | in_ready=1, waiting for a request; operands captured on accept
//   RUN    | one shift / multiply / divide step per cycle, down-counter paced
//   DONE   | out_valid=1 for one cycle, results held in output registers
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       F,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic [5:0]       Status
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] OP_INC  = 5'b00001;
    localparam logic [4:0] OP_DEC  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADC  = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SBB  = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_OR   = 5'b01001;
    localparam logic [4:0] OP_XOR  = 5'b01010;
    localparam logic [4:0] OP_NOT  = 5'b01011;
    localparam logic [4:0] OP_SHL  = 5'b10000;
    localparam logic [4:0] OP_SHR  = 5'b10001;
    localparam logic [4:0] OP_SAL  = 5'b10010;
    localparam logic [4:0] OP_SAR  = 5'b10011;
    localparam logic [4:0] OP_ROL  = 5'b10100;
    localparam logic [4:0] OP_ROR  = 5'b10101;
    localparam logic [4:0] OP_RCL  = 5'b10110;
    localparam logic [4:0] OP_RCR  = 5'b10111;
    localparam logic [4:0] OP_SHLN = 5'b11000;
    localparam logic [4:0] OP_SHRN = 5'b11001;
    localparam logic [4:0] OP_SARN = 5'b11010;
    localparam logic [4:0] OP_ROLN = 5'b11011;
    localparam logic [4:0] OP_RORN = 5'b11100;
    localparam logic [4:0] OP_MUL  = 5'b11101;
    localparam logic [4:0] OP_DIV  = 5'b11110;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW:0]      CNT_FULL = (CW+1)'(WIDTH);
    localparam logic [CW:0]      CNT_ONE  = {{CW{1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] wk_lo;
    logic [WIDTH-1:0] wk_hi;
    logic [WIDTH-1:0] op_b;
    logic [CW:0]      cnt;

    logic [WIDTH-1:0] ar_y;
    logic             ar_ci;
    logic             ar_sub;
    logic [WIDTH:0]   ar_full;
    logic             ar_v;
    logic [WIDTH-1:0] s_res;
    logic             s_c;
    logic             s_v;
    logic             s_ac;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] st_lo;
    logic [WIDTH-1:0] st_hi;
    logic             st_c;
    logic [WIDTH-1:0] fin_hi;
    logic             fin_c;
    logic             fin_v;

    logic [CW-1:0]    shn;
    logic             is_shn;

    function automatic logic [5:0] pack_status(input logic [WIDTH-1:0] r,
                                               input logic c, input logic v,
                                               input logic ac);
        return {c, (r == '0), r[WIDTH-1], v, ~^r, ac};
    endfunction

    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = (state == S_DONE);
    assign shn       = B[CW-1:0];
    assign is_shn    = (F >= OP_SHLN) && (F <= OP_RORN);

    // Single-step datapath evaluated on the live inputs, latched on acceptance.
    always_comb begin
        ar_y   = B;
        ar_ci  = 1'b0;
        ar_sub = 1'b0;
        case (F)
            OP_INC:  ar_y = ONE;
            OP_DEC:  begin ar_y = ONE; ar_sub = 1'b1; end
            OP_ADC:  ar_ci = Cin;
            OP_SUB:  ar_sub = 1'b1;
            OP_SBB:  begin ar_sub = 1'b1; ar_ci = Cin; end
            default: ;
        endcase
        if (ar_sub) begin
            ar_full = {1'b0, A} - {1'b0, ar_y} - {{WIDTH{1'b0}}, ar_ci};
            ar_v    = (A[WIDTH-1] != ar_y[WIDTH-1]) && (ar_full[WIDTH-1] != A[WIDTH-1]);
        end else begin
            ar_full = {1'b0, A} + {1'b0, ar_y} + {{WIDTH{1'b0}}, ar_ci};
            ar_v    = (A[WIDTH-1] == ar_y[WIDTH-1]) && (ar_full[WIDTH-1] != A[WIDTH-1]);
        end

        s_res = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        s_ac  = 1'b0;
        case (F)
            OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
                s_res = ar_full[WIDTH-1:0];
                s_c   = ar_full[WIDTH];
                s_v   = ar_v;
                // Carry/borrow into bit 4 recovered from the bit-4 sum.
                s_ac  = A[4] ^ ar_y[4] ^ ar_full[4];
            end
            OP_AND:         s_res = A & B;
            OP_OR:          s_res = A | B;
            OP_XOR:         s_res = A ^ B;
            OP_NOT:         s_res = ~A;
            OP_SHL, OP_SAL: begin s_res = {A[WIDTH-2:0], 1'b0};       s_c = A[WIDTH-1]; end
            OP_SHR:         begin s_res = {1'b0, A[WIDTH-1:1]};       s_c = A[0];       end
            OP_SAR:         begin s_res = {A[WIDTH-1], A[WIDTH-1:1]}; s_c = A[0];       end
            OP_ROL:         begin s_res = {A[WIDTH-2:0], A[WIDTH-1]}; s_c = A[WIDTH-1]; end
            OP_ROR:         begin s_res = {A[0], A[WIDTH-1:1]};       s_c = A[0];       end
            OP_RCL:         begin s_res = {A[WIDTH-2:0], Cin};        s_c = A[WIDTH-1]; end
            OP_RCR:         begin s_res = {Cin, A[WIDTH-1:1]};        s_c = A[0];       end
            default: ;
        endcase
    end

    // One iteration of the captured multi-cycle op, plus its final flags.
    always_comb begin
        st_lo    = wk_lo;
        st_hi    = wk_hi;
        st_c     = 1'b0;
        mul_sum  = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, op_b} : {(WIDTH+1){1'b0}});
        div_sh   = {wk_hi, wk_lo[WIDTH-1]};
        // Only used when div_sh >= op_b, where the difference fits in WIDTH bits.
        div_diff = div_sh[WIDTH-1:0] - op_b;
        case (op_q)
            OP_SHLN: begin st_lo = {wk_lo[WIDTH-2:0], 1'b0};           st_c = wk_lo[WIDTH-1]; end
            OP_SHRN: begin st_lo = {1'b0, wk_lo[WIDTH-1:1]};           st_c = wk_lo[0];       end
            OP_SARN: begin st_lo = {wk_lo[WIDTH-1], wk_lo[WIDTH-1:1]}; st_c = wk_lo[0];       end
            OP_ROLN: begin st_lo = {wk_lo[WIDTH-2:0], wk_lo[WIDTH-1]}; st_c = wk_lo[WIDTH-1]; end
            OP_RORN: begin st_lo = {wk_lo[0], wk_lo[WIDTH-1:1]};       st_c = wk_lo[0];       end
            OP_MUL: begin
                st_hi = mul_sum[WIDTH:1];
                st_lo = {mul_sum[0], wk_lo[WIDTH-1:1]};
            end
            OP_DIV: begin
                if (div_sh >= {1'b0, op_b}) begin
                    st_hi = div_diff;
                    st_lo = {wk_lo[WIDTH-2:0], 1'b1};
                end else begin
                    st_hi = div_sh[WIDTH-1:0];
                    st_lo = {wk_lo[WIDTH-2:0], 1'b0};
                end
            end
            default: ;
        endcase

        fin_hi = ((op_q == OP_MUL) || (op_q == OP_DIV)) ? st_hi : '0;
        fin_v  = (op_q == OP_MUL) && (st_hi != '0);
        fin_c  = (op_q == OP_MUL) ? fin_v : ((op_q == OP_DIV) ? 1'b0 : st_c);
    end

    // Handshake state machine, iteration registers and held output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            wk_lo    <= '0;
            wk_hi    <= '0;
            op_b     <= '0;
            cnt      <= '0;
            Result   <= '0;
            ResultHi <= '0;
            Status   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= F;
                        if (is_shn) begin
                            if (shn == '0) begin
                                Result   <= A;
                                ResultHi <= '0;
                                Status   <= pack_status(A, 1'b0, 1'b0, 1'b0);
                                state    <= S_DONE;
                            end else begin
                                wk_lo <= A;
                                cnt   <= {1'b0, shn};
                                state <= S_RUN;
                            end
                        end else if (F == OP_MUL) begin
                            wk_lo <= B;
                            wk_hi <= '0;
                            op_b  <= A;
                            cnt   <= CNT_FULL;
                            state <= S_RUN;
                        end else if (F == OP_DIV) begin
                            if (B == '0) begin
                                Result   <= '1;
                                ResultHi <= A;
                                Status   <= pack_status('1, 1'b0, 1'b1, 1'b0);
                                state    <= S_DONE;
                            end else begin
                                wk_lo <= A;
                                wk_hi <= '0;
                                op_b  <= B;
                                cnt   <= CNT_FULL;
                                state <= S_RUN;
                            end
                        end else begin
                            Result   <= s_res;
                            ResultHi <= '0;
                            Status   <= pack_status(s_res, s_c, s_v, s_ac);
                            state    <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    wk_lo <= st_lo;
                    wk_hi <= st_hi;
                    cnt   <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        Result   <= st_lo;
                        ResultHi <= fin_hi;
                        Status   <= pack_status(st_lo, fin_c, fin_v, 1'b0);
                        state    <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed + randomised bench for alu_seq (WIDTH=16) with an expected-result queue.
module tb_alu_seq;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] hi;
        logic [5:0]  st;
        logic [7:0]  lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic [4:0]  F;
    logic        Cin;
    logic        out_valid;
    logic [15:0] Result;
    logic [15:0] ResultHi;
    logic [5:0]  Status;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    alu_seq #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .F        (F),
        .Cin      (Cin),
        .out_valid(out_valid),
        .Result   (Result),
        .ResultHi (ResultHi),
        .Status   (Status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] r, input logic [15:0] h,
                                input logic [5:0] s, input int l);
        exp_t e;
        e.res = r; e.hi = h; e.st = s; e.lat = 8'(l);
        return e;
    endfunction

    // Behavioural reference using integer arithmetic.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [4:0] f, input logic cin);
        exp_t        e;
        logic [15:0] r, y;
        logic        c, v, ac;
        logic [31:0] p;
        int          ci, full, sx, n;
        bit          is_add, is_sub;
        r = '0; c = 0; v = 0; ac = 0; y = b; ci = 0; is_add = 0; is_sub = 0;
        e.hi = '0; e.lat = 8'd1;
        case (f)
            5'b00001: begin is_add = 1; y = 16'd1; end
            5'b00100: is_add = 1;
            5'b00101: begin is_add = 1; ci = int'(cin); end
            5'b00011: begin is_sub = 1; y = 16'd1; end
            5'b00110: is_sub = 1;
            5'b00111: begin is_sub = 1; ci = int'(cin); end
            5'b01000: r = a & b;
            5'b01001: r = a | b;
            5'b01010: r = a ^ b;
            5'b01011: r = ~a;
            5'b10000, 5'b10010: begin r = a << 1; c = a[15]; end
            5'b10001: begin r = a >> 1; c = a[0]; end
            5'b10011: begin r = 16'($signed(a) >>> 1); c = a[0]; end
            5'b10100: begin r = (a << 1) | (a >> 15); c = a[15]; end
            5'b10101: begin r = (a >> 1) | (a << 15); c = a[0]; end
            5'b10110: begin r = (a << 1) | {15'd0, cin}; c = a[15]; end
            5'b10111: begin r = (a >> 1) | {cin, 15'd0}; c = a[0]; end
            5'b11000, 5'b11001, 5'b11010, 5'b11011, 5'b11100: begin
                n = int'(b[3:0]);
                r = a;
                for (int i = 0; i < n; i++) begin
                    case (f)
                        5'b11000: begin c = r[15]; r = r << 1; end
                        5'b11001: begin c = r[0];  r = r >> 1; end
                        5'b11010: begin c = r[0];  r = 16'($signed(r) >>> 1); end
                        5'b11011: begin c = r[15]; r = (r << 1) | (r >> 15); end
                        default:  begin c = r[0];  r = (r >> 1) | (r << 15); end
                    endcase
                end
                e.lat = (n == 0) ? 8'd1 : 8'(n + 1);
            end
            5'b11101: begin
                p = {16'd0, a} * {16'd0, b};
                r = p[15:0]; e.hi = p[31:16];
                c = (e.hi != 0); v = c; e.lat = 8'd17;
            end
            5'b11110: begin
                if (b == 0) begin r = 16'hFFFF; e.hi = a; v = 1; e.lat = 8'd1; end
                else begin r = a / b; e.hi = a % b; e.lat = 8'd17; end
            end
            default: r = '0;
        endcase
        if (is_add) begin
            full = int'(a) + int'(y) + ci;
            r    = full[15:0];
            c    = full > 65535;
            sx   = int'($signed(a)) + int'($signed(y)) + ci;
            v    = (sx > 32767) || (sx < -32768);
            ac   = (int'(a[3:0]) + int'(y[3:0]) + ci) > 15;
        end
        if (is_sub) begin
            full = int'(a) - int'(y) - ci;
            r    = full[15:0];
            c    = full < 0;
            sx   = int'($signed(a)) - int'($signed(y)) - ci;
            v    = (sx > 32767) || (sx < -32768);
            ac   = (int'(a[3:0]) - int'(y[3:0]) - ci) < 0;
        end
        e.res = r;
        e.st  = {c, (r == 16'd0), r[15], v, ~^r, ac};
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [4:0] f, input logic cin, input exp_t e, input bit noise);
        bit   got, rdy, ready_bad;
        int   lat;
        exp_t x;
        rdy = 0;
        for (int k = 0; k < 50 && !rdy; k++) begin
            @(negedge clk);
            rdy = in_ready;
        end
        if (!rdy) begin
            check({tag, "_ready_timeout"}, 0, 1);
            return;
        end
        sb_q.push_back(e);
        A = a; B = b; F = f; Cin = cin; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 16'($urandom); B = 16'($urandom); F = 5'($urandom); Cin = 1'($urandom);
        got = 0; lat = 0; ready_bad = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1; lat = k; in_valid = 1'b0;
            end else begin
                if (in_ready !== 1'b0) ready_bad = 1;
                if (noise) begin
                    in_valid = 1'b1;
                    A = 16'($urandom); B = 16'($urandom); F = 5'($urandom);
                end
            end
        end
        x = sb_q.pop_front();
        if (!got) begin
            check({tag, "_out_valid_timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        check({tag, "_result"}, Result, x.res);
        check({tag, "_result_hi"}, ResultHi, x.hi);
        check({tag, "_status"}, Status, x.st);
        check({tag, "_latency"}, lat, x.lat);
        if (x.lat > 1) check({tag, "_busy_ready"}, ready_bad, 0);
        @(negedge clk);
        check({tag, "_pulse_width"}, out_valid, 0);
        check({tag, "_ready_after"}, in_ready, 1);
        check({tag, "_hold"}, Result, x.res);
    endtask

    task automatic run_model(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [4:0] f, input logic cin);
        run_op(tag, a, b, f, cin, model(a, b, f, cin), 1'b0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; F = '0; Cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", Result, 0);
        check("reset_result_hi", ResultHi, 0);
        check("reset_status", Status, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", in_ready, 1);

        // Directed cases with hand-derived expectations.
        run_op("add_ovf",  16'h7FFF, 16'h0001, 5'b00100, 1'b0, mk(16'h8000, 16'h0000, 6'b001101, 1),  1'b0);
        run_op("mul",      16'h1234, 16'h0100, 5'b11101, 1'b0, mk(16'h3400, 16'h0012, 6'b100100, 17), 1'b1);
        run_op("div",      16'h0064, 16'h0007, 5'b11110, 1'b0, mk(16'h000E, 16'h0002, 6'b000000, 17), 1'b0);
        run_op("div_zero", 16'h1234, 16'h0000, 5'b11110, 1'b0, mk(16'hFFFF, 16'h1234, 6'b001110, 1),  1'b0);
        run_op("shrn4",    16'h8001, 16'h0004, 5'b11001, 1'b0, mk(16'h0800, 16'h0000, 6'b000000, 5),  1'b0);
        run_op("sarn4",    16'h8001, 16'h0004, 5'b11010, 1'b0, mk(16'hF800, 16'h0000, 6'b001000, 5),  1'b0);
        run_op("rorn1",    16'h8001, 16'h0001, 5'b11100, 1'b0, mk(16'hC000, 16'h0000, 6'b101010, 2),  1'b0);
        run_op("shln0",    16'h8001, 16'h0000, 5'b11000, 1'b0, mk(16'h8001, 16'h0000, 6'b001010, 1),  1'b0);
        run_op("bad_op",   16'h5A5A, 16'h1234, 5'b01100, 1'b1, mk(16'h0000, 16'h0000, 6'b010010, 1),  1'b0);

        // Model-checked coverage of the remaining opcodes and boundaries.
        run_model("adc",   16'hFFFF, 16'h0000, 5'b00101, 1'b1);
        run_model("sub",   16'h8000, 16'h0001, 5'b00110, 1'b0);
        run_model("sbb",   16'h0010, 16'h0001, 5'b00111, 1'b1);
        run_model("inc",   16'hFFFF, 16'h0000, 5'b00001, 1'b0);
        run_model("dec",   16'h0000, 16'h0000, 5'b00011, 1'b0);
        run_model("and",   16'hF0F0, 16'h3C3C, 5'b01000, 1'b0);
        run_model("or",    16'hF0F0, 16'h0F0F, 5'b01001, 1'b0);
        run_model("xor",   16'hAAAA, 16'hAAAA, 5'b01010, 1'b0);
        run_model("not",   16'h00FF, 16'h0000, 5'b01011, 1'b0);
        run_model("shl",   16'h8001, 16'h0000, 5'b10000, 1'b0);
        run_model("shr",   16'h8001, 16'h0000, 5'b10001, 1'b0);
        run_model("sal",   16'h4003, 16'h0000, 5'b10010, 1'b0);
        run_model("sar",   16'h8003, 16'h0000, 5'b10011, 1'b0);
        run_model("rol",   16'h8001, 16'h0000, 5'b10100, 1'b0);
        run_model("ror",   16'h8001, 16'h0000, 5'b10101, 1'b0);
        run_model("rcl",   16'h0001, 16'h0000, 5'b10110, 1'b1);
        run_model("rcr",   16'h0002, 16'h0000, 5'b10111, 1'b1);
        run_model("shln15", 16'h0003, 16'h000F, 5'b11000, 1'b0);
        run_model("roln3", 16'hE001, 16'h0003, 5'b11011, 1'b0);
        run_model("mul_max", 16'hFFFF, 16'hFFFF, 5'b11101, 1'b0);
        run_model("mul_small", 16'h0003, 16'h0005, 5'b11101, 1'b0);
        run_model("div_one", 16'hFFFF, 16'h0001, 5'b11110, 1'b0);
        run_model("div_big", 16'h0005, 16'hFFFF, 5'b11110, 1'b0);

        for (int i = 0; i < 12; i++) begin
            run_model("rand", 16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom));
        end

        // Abort a multiply part way through with rst.
        seen = 0;
        @(negedge clk);
        A = 16'h1234; B = 16'h0100; F = 5'b11101; Cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_result", Result, 0);
        check("abort_result_hi", ResultHi, 0);
        check("abort_status", Status, 0);
        check("abort_in_ready_in_rst", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready_after", in_ready, 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("abort_no_pulse", seen, 0);

        run_op("after_abort", 16'h0064, 16'h0007, 5'b11110, 1'b0,
               mk(16'h000E, 16'h0002, 6'b000000, 17), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
